uart_cmd_assembler: RTL and testbench
=====================================

# uart_cmd_assembler

Consumes the byte stream produced by the UART receiver (its `rdy`/`rx_data`/`clr_rdy` handshake) and assembles three consecutive bytes into one 24-bit command (8-bit opcode plus 16-bit operand) for the command-processing logic. It acknowledges each byte back to the receiver and presents completed commands with a `cmd_rdy`/`clr_cmd_rdy` handshake. An inter-byte timeout discards partial commands so the link resynchronises after a dropped byte.

## Interface
- `TIMEOUT`, default 78120: maximum clocks allowed between accepted bytes of one command (3 byte-times at 2604 clk/bit, 10 bits/byte).
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  receiver byte-valid; stays high until cleared.
- `rx_data`  in  8  received byte, stable while `rdy` is high.
- `clr_rdy`  out  1  combinational one-cycle acknowledge to the receiver.
- `cmd`  out  24  last completed command; `cmd[23:16]` opcode.
- `cmd_rdy`  out  1  completed command pending.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `timeout`  out  1  one-cycle pulse when a partial command is discarded.

## Operation
- States: `WAIT_B0`, `WAIT_B1`, `WAIT_B2`, `FULL`.
- Accept condition: `rdy` high in `WAIT_B0`, `WAIT_B1` or `WAIT_B2`. In that cycle `clr_rdy`=1 (combinational from `rdy` and state). The byte is captured at the closing edge, and the state advances.
- `clr_rdy` is 0 in `FULL` and whenever `rdy` is 0.
- `WAIT_B0`: byte goes to staging `hi`, then go to `WAIT_B1`.
- `WAIT_B1`: byte goes to staging `mid`, then go to `WAIT_B2`.
- `WAIT_B2`: at the same edge, `cmd` <= {hi, mid, rx_data} and `cmd_rdy` <= 1. Go to `FULL`.
- `cmd` changes only at that edge. Partial assembly never disturbs `cmd`.
- `FULL`: `rdy` is not consumed. The receiver holds its byte, which gives backpressure. On `clr_cmd_rdy`, `cmd_rdy` <= 0 and the state goes to `WAIT_B0`. A `rdy` present in that same cycle is not accepted; the earliest acceptance is the next cycle.
- `clr_cmd_rdy` outside `FULL` has no effect.
- Timeout counter: width ceil(log2(TIMEOUT)).
  - Cleared on every accepted byte and whenever the state is `WAIT_B0` or `FULL`.
  - Increments each cycle in `WAIT_B1`/`WAIT_B2` without an accept.
  - When the count reaches TIMEOUT-1 with no accept in that cycle: next state is `WAIT_B0`, the counter clears, the staging bytes are discarded, and `timeout` pulses high for exactly one cycle (registered).
  - If an accept and expiry coincide, the accept wins: the byte is taken, the counter clears, and there is no `timeout`.
- Reset (asynchronous, any state, mid-command included): state `WAIT_B0`, `cmd`=24'h000000, `cmd_rdy`=0, `timeout`=0, counter=0, staging=0. `clr_rdy` follows combinationally and is 0 in reset.

## Timing
- Byte acceptance: same cycle as `rdy` is seen high; `clr_rdy` is high for that single cycle.
- `cmd_rdy` rises on the edge that accepts byte 2.
- `cmd_rdy` falls on the edge where `clr_cmd_rdy` is sampled high.
- Throughput: one byte per cycle maximum. There are no bubbles between bytes of a command. There is one mandatory idle cycle after `clr_cmd_rdy`.
- `timeout` asserts the cycle after the expiry edge and lasts exactly 1 cycle.

## Test plan
- Bytes 8'hA5, 8'h12, 8'h34 on `rdy` with gaps of 2604 cycles. Required: `clr_rdy` pulses 3 times, 1 cycle each; `cmd`=24'hA51234 and `cmd_rdy`=1 after the third accept; `timeout` stays 0.
- Backpressure: with `cmd_rdy` high, present 8'h77 with `rdy` held for 100 cycles. Required: `clr_rdy`=0 throughout and `cmd` unchanged. Then pulse `clr_cmd_rdy`. Required: `cmd_rdy`=0 the next cycle and 8'h77 accepted one cycle later as the new opcode.
- Timeout: send 8'h01, then nothing. Required: `timeout` pulses once at TIMEOUT cycles after the accept, state returns to `WAIT_B0`, and `cmd` is unchanged. Then send 8'h02, 8'h03, 8'h04. Required: `cmd`=24'h020304.
- Boundary: with TIMEOUT=16, send byte 1, then byte 2 exactly on the expiry cycle. Required: the byte is accepted, `timeout` stays 0, and the counter restarts.
- Reset mid-command: assert `rst` after 2 bytes. Required: all outputs take their reset values immediately (asynchronously). After release, 3 new bytes 8'hFF, 8'h00, 8'hFF give `cmd`=24'hFF00FF.
- Spurious `clr_cmd_rdy` in `WAIT_B1`. Required: no state or output change.

Source files
------------

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: packs three UART bytes into a 24-bit opcode/operand command,
// with receiver backpressure while a command is pending and an inter-byte timeout.
module uart_cmd_assembler #(
  parameter int TIMEOUT = 78120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        timeout
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, FULL} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] hi;
  logic [7:0] mid;
  logic expire;
  assign clr_rdy = rdy && !rst && state != FULL;
  // an accept in the expiry cycle wins over the timeout
  assign expire = (state == WAIT_B1 || state == WAIT_B2) && !clr_rdy && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WAIT_B0;
      cnt <= '0;
      hi <= '0;
      mid <= '0;
      cmd <= '0;
      cmd_rdy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      cnt <= (clr_rdy || expire || state == WAIT_B0 || state == FULL) ? '0 : cnt + 1'b1;
      if (expire) begin
        state <= WAIT_B0;
        hi <= '0;
        mid <= '0;
      end else if (state == FULL) begin
        if (clr_cmd_rdy) begin
          state <= WAIT_B0;
          cmd_rdy <= 1'b0;
        end
      end else if (clr_rdy) begin
        case (state)
          WAIT_B0: begin
            hi <= rx_data;
            state <= WAIT_B1;
          end
          WAIT_B1: begin
            mid <= rx_data;
            state <= WAIT_B2;
          end
          default: begin
            cmd <= {hi, mid, rx_data};
            cmd_rdy <= 1'b1;
            state <= FULL;
            hi <= '0;
            mid <= '0;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb_uart_cmd_assembler: directed and random checks of uart_cmd_assembler against
// a byte-queue reference model (short TIMEOUT so expiry is reachable quickly).
module tb_uart_cmd_assembler;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst, rdy, clr_cmd_rdy, clr_rdy, cmd_rdy, timeout;
  logic [7:0] rx_data;
  logic [23:0] cmd;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic m_full, m_to;
  logic [23:0] m_cmd;
  int m_idle;

  always #5 clk = ~clk;

  uart_cmd_assembler #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .timeout(timeout)
  );

  task automatic model_reset();
    q.delete();
    m_full = 1'b0;
    m_to = 1'b0;
    m_cmd = '0;
    m_idle = 0;
  endtask

  // one clock: drive inputs, sample clr_rdy mid-cycle, advance the model at the edge
  task automatic step(input logic r, input logic [7:0] d, input logic c,
                      output logic co, output logic ce);
    rdy = r;
    rx_data = d;
    clr_cmd_rdy = c;
    #1;
    co = clr_rdy;
    ce = r && !m_full;
    @(posedge clk);
    m_to = 1'b0;
    if (m_full) begin
      if (c) m_full = 1'b0;
    end else if (r) begin
      q.push_back(d);
      m_idle = 0;
      if (q.size() == 3) begin
        m_cmd = {q[0], q[1], q[2]};
        q.delete();
        m_full = 1'b1;
      end
    end else if (q.size() > 0) begin
      m_idle = m_idle + 1;
      if (m_idle == TO) begin
        q.delete();
        m_idle = 0;
        m_to = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    rx_data = 8'h5A;
    clr_cmd_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({clr_rdy, cmd, cmd_rdy, timeout} !== 27'd0) begin
      errors++;
      $display("FAIL reset_hold: got clr_rdy=%b cmd=%h cmd_rdy=%b timeout=%b, want all 0", clr_rdy, cmd, cmd_rdy, timeout);
    end
    rst = 1'b0;
    rdy = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({clr_rdy, cmd, cmd_rdy, timeout} !== 27'd0) begin
      errors++;
      $display("FAIL reset_release: got clr_rdy=%b cmd=%h cmd_rdy=%b timeout=%b, want all 0", clr_rdy, cmd, cmd_rdy, timeout);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bs[3] = '{8'hA5, 8'h12, 8'h34};
    logic co, ce;
    int pulses = 0;
    int tos = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, bs[i], 1'b0, co, ce);
      pulses += int'(co);
      tos += int'(timeout);
      repeat (10) begin
        step(1'b0, 8'h00, 1'b0, co, ce);
        pulses += int'(co);
        tos += int'(timeout);
      end
    end
    checks++;
    if (pulses != 3 || tos != 0) begin
      errors++;
      $display("FAIL basic_pulses: got clr_rdy pulses=%0d timeouts=%0d, want 3 and 0", pulses, tos);
    end
    checks++;
    if (cmd !== 24'hA51234 || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_cmd: got cmd=%h cmd_rdy=%b, want a51234 1", cmd, cmd_rdy);
    end
    checks++;
    if ({cmd, cmd_rdy, timeout} !== {m_cmd, m_full, m_to}) begin
      errors++;
      $display("FAIL basic_model: got %h/%b/%b, want %h/%b/%b", cmd, cmd_rdy, timeout, m_cmd, m_full, m_to);
    end
  endtask

  task automatic test_backpressure();
    logic co, ce;
    int bad = 0;
    repeat (100) begin
      step(1'b1, 8'h77, 1'b0, co, ce);
      if (co !== 1'b0 || cmd !== 24'hA51234 || cmd_rdy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles, want 0", bad);
    end
    step(1'b1, 8'h77, 1'b1, co, ce);
    checks++;
    if (co !== 1'b0 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got clr_rdy=%b cmd_rdy=%b, want 0 0", co, cmd_rdy);
    end
    step(1'b1, 8'h77, 1'b0, co, ce);
    checks++;
    if (co !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: got clr_rdy=%b, want 1", co);
    end
    step(1'b1, 8'h9A, 1'b0, co, ce);
    step(1'b1, 8'hBC, 1'b0, co, ce);
    checks++;
    if (cmd !== 24'h779ABC || cmd_rdy !== 1'b1 || cmd !== m_cmd) begin
      errors++;
      $display("FAIL bp_cmd: got cmd=%h cmd_rdy=%b, want 779abc 1", cmd, cmd_rdy);
    end
    step(1'b0, 8'h00, 1'b1, co, ce);
  endtask

  task automatic test_timeout();
    logic co, ce;
    int first = -1;
    int cnt = 0;
    int bad = 0;
    step(1'b1, 8'h01, 1'b0, co, ce);
    for (int i = 1; i <= TO + 4; i++) begin
      step(1'b0, 8'h00, 1'b0, co, ce);
      if (timeout !== m_to) bad++;
      if (timeout === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (cnt != 1 || first != TO || bad != 0) begin
      errors++;
      $display("FAIL to_pulse: got %0d pulses first at %0d model_diff=%0d, want 1 at %0d", cnt, first, bad, TO);
    end
    checks++;
    if (cmd !== 24'h779ABC || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL to_cmd_kept: got cmd=%h cmd_rdy=%b, want 779abc 0", cmd, cmd_rdy);
    end
    step(1'b1, 8'h02, 1'b0, co, ce);
    step(1'b1, 8'h03, 1'b0, co, ce);
    step(1'b1, 8'h04, 1'b0, co, ce);
    checks++;
    if (cmd !== 24'h020304 || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL to_resync: got cmd=%h cmd_rdy=%b, want 020304 1", cmd, cmd_rdy);
    end
    step(1'b0, 8'h00, 1'b1, co, ce);
  endtask

  task automatic test_boundary();
    logic co, ce;
    int tos = 0;
    step(1'b1, 8'h11, 1'b0, co, ce);
    repeat (TO - 1) begin
      step(1'b0, 8'h00, 1'b0, co, ce);
      tos += int'(timeout);
    end
    step(1'b1, 8'h22, 1'b0, co, ce);
    checks++;
    if (co !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL bnd_accept: got clr_rdy=%b timeout=%b, want 1 0", co, timeout);
    end
    repeat (TO - 1) begin
      step(1'b0, 8'h00, 1'b0, co, ce);
      tos += int'(timeout);
    end
    step(1'b1, 8'h33, 1'b0, co, ce);
    tos += int'(timeout);
    checks++;
    if (co !== 1'b1 || tos != 0 || cmd !== 24'h112233 || cmd !== m_cmd) begin
      errors++;
      $display("FAIL bnd_restart: got clr_rdy=%b timeouts=%0d cmd=%h, want 1 0 112233", co, tos, cmd);
    end
    step(1'b0, 8'h00, 1'b1, co, ce);
  endtask

  task automatic test_reset_mid();
    logic co, ce;
    step(1'b1, 8'hAA, 1'b0, co, ce);
    step(1'b1, 8'hBB, 1'b0, co, ce);
    rdy = 1'b1;
    rx_data = 8'hCC;
    #2;
    checks++;
    if (clr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got clr_rdy=%b, want 1", clr_rdy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({clr_rdy, cmd, cmd_rdy, timeout} !== 27'd0) begin
      errors++;
      $display("FAIL rst_async: got clr_rdy=%b cmd=%h cmd_rdy=%b timeout=%b, want all 0", clr_rdy, cmd, cmd_rdy, timeout);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'hFF, 1'b0, co, ce);
    step(1'b1, 8'h00, 1'b0, co, ce);
    step(1'b1, 8'hFF, 1'b0, co, ce);
    checks++;
    if (cmd !== 24'hFF00FF || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: got cmd=%h cmd_rdy=%b, want ff00ff 1", cmd, cmd_rdy);
    end
    step(1'b0, 8'h00, 1'b1, co, ce);
  endtask

  task automatic test_spurious();
    logic co, ce;
    int bad = 0;
    step(1'b1, 8'h5C, 1'b0, co, ce);
    repeat (3) begin
      step(1'b0, 8'h00, 1'b1, co, ce);
      if (co !== 1'b0 || cmd !== 24'hFF00FF || cmd_rdy !== 1'b0 || timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spur_hold: got %0d disturbed cycles, want 0", bad);
    end
    step(1'b1, 8'h6D, 1'b0, co, ce);
    step(1'b1, 8'h7E, 1'b0, co, ce);
    checks++;
    if (cmd !== 24'h5C6D7E || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL spur_cmd: got cmd=%h cmd_rdy=%b, want 5c6d7e 1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_random();
    logic co, ce, pend, c;
    logic [7:0] b = 8'h00;
    int gap = 0;
    pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && gap == 0) begin
        pend = 1'b1;
        b = 8'($urandom);
      end else if (!pend) begin
        gap--;
      end
      c = ($urandom_range(0, 3) == 0);
      step(pend, b, c, co, ce);
      checks++;
      if (co !== ce || {cmd, cmd_rdy, timeout} !== {m_cmd, m_full, m_to}) begin
        errors++;
        $display("FAIL rand_cycle%0d: got clr_rdy=%b %h/%b/%b, want clr_rdy=%b %h/%b/%b",
                 i, co, cmd, cmd_rdy, timeout, ce, m_cmd, m_full, m_to);
      end
      if (co === 1'b1) begin
        pend = 1'b0;
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
